// File: rtl/render_stream_source.sv
// Head-of-chain pixel-stream source: host register writes become program beats, frame requests become background raster scans, and idle cycles carry NOPs.
// Latency: a command or frame request reaches the outputs two cycles after it is accepted. Backpressure: cmd_ready drops while the command FIFO is full.
module render_stream_source #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_stage,
  input  logic [11:0] cmd_reg,
  input  logic [11:0] cmd_data,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic        program_out,
  output logic [11:0] x_out,
  output logic [11:0] y_out,
  output logic [11:0] data_out
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [11:0] X_LAST = 12'(H_RES - 1);
  localparam logic [11:0] Y_LAST = 12'(V_RES - 1);
  localparam logic [AW:0] FULL   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE    = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, PROGRAM, SCAN} state_t;

  state_t        state, state_nxt;
  logic [35:0]   mem [FIFO_DEPTH];
  logic [35:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop, fifo_empty, last_entry;
  logic          pending, pending_nxt;
  logic [11:0]   x_cnt, y_cnt;
  logic          last_pix, scan_enter;

  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == PROGRAM);
  assign fifo_empty = (count == '0);
  assign last_entry = (count == ONE) && !push;
  assign count_nxt  = count + (AW + 1)'(push) - (AW + 1)'(pop);
  assign head       = mem[rd_ptr];
  assign last_pix   = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty)  state_nxt = PROGRAM;
        else if (pending) state_nxt = SCAN;
      end
      PROGRAM: begin
        // Chain straight into a pending frame so there is no NOP gap.
        if (last_entry) state_nxt = pending ? SCAN : IDLE;
      end
      SCAN: begin
        if (last_pix) begin
          if (!fifo_empty)  state_nxt = PROGRAM;
          else if (pending) state_nxt = SCAN;
          else              state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Any transition into SCAN, including a back-to-back frame restart.
  assign scan_enter  = (state_nxt == SCAN) && !((state == SCAN) && !last_pix);
  assign pending_nxt = frame_start || (pending && !scan_enter);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_stage, cmd_reg, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pending   <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      pending   <= pending_nxt;
      cmd_ready <= (count_nxt != FULL);
      busy      <= pending_nxt || (state_nxt == SCAN);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (scan_enter) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (state == SCAN) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 12'd1;
        end else begin
          x_cnt <= x_cnt + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      program_out <= 1'b1;
      x_out       <= 12'hFFF;
      y_out       <= '0;
      data_out    <= '0;
      frame_done  <= 1'b0;
    end else begin
      program_out <= 1'b1;
      x_out       <= 12'hFFF;
      y_out       <= '0;
      data_out    <= '0;
      frame_done  <= 1'b0;
      case (state)
        PROGRAM: begin
          x_out    <= head[35:24];
          y_out    <= head[23:12];
          data_out <= head[11:0];
        end
        SCAN: begin
          program_out <= 1'b0;
          x_out       <= x_cnt;
          y_out       <= y_cnt;
          data_out    <= BG_COLOR;
          frame_done  <= last_pix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_render_stream_source.sv
// Scenario bench for render_stream_source: expected beats are queued as stimulus is driven and compared as the DUT emits them.
module tb_render_stream_source;

  localparam int          H  = 8;
  localparam int          V  = 4;
  localparam int          D  = 16;
  localparam logic [11:0] BG = 12'hA5C;

  typedef struct packed {
    logic        prog;
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] d;
    logic        done;
  } beat_t;

  localparam beat_t NOP_BEAT = {1'b1, 12'hFFF, 12'h000, 12'h000, 1'b0};

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_stage, cmd_reg, cmd_data;
  logic        frame_start;
  logic        busy, frame_done, program_out;
  logic [11:0] x_out, y_out, data_out;

  beat_t obs;
  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  render_stream_source #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D), .BG_COLOR(BG)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_stage(cmd_stage), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .program_out(program_out), .x_out(x_out), .y_out(y_out), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t mk(input logic p, input logic [11:0] x, input logic [11:0] y,
                               input logic [11:0] d, input logic dn);
    return {p, x, y, d, dn};
  endfunction

  function automatic bit is_nop(input beat_t b);
    return b === NOP_BEAT;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    obs = {program_out, x_out, y_out, data_out, frame_done};
  endtask

  task automatic push_frame();
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        exp_q.push_back(mk(1'b0, 12'(xx), 12'(yy), BG, (xx == H - 1) && (yy == V - 1)));
  endtask

  task automatic test_reset();
    rst_n = 0; cmd_valid = 1; frame_start = 1;
    cmd_stage = 12'd1; cmd_reg = 12'd1; cmd_data = 12'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
      n_checks++;
      if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL reset_nop: got %h expected %h", obs, NOP_BEAT); end
    end
    rst_n = 1; cmd_valid = 0; frame_start = 0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL reset_no_push: got %h expected %h", obs, NOP_BEAT); end
    end
  endtask

  task automatic test_single_cmd();
    beat_t e;
    cmd_valid = 1; cmd_stage = 12'd0; cmd_reg = 12'd2; cmd_data = 12'd50;
    exp_q.push_back(mk(1'b1, 12'd0, 12'd2, 12'd50, 1'b0));
    tick();
    cmd_valid = 0;
    n_checks++;
    if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL single_edge_n: got %h expected %h", obs, NOP_BEAT); end
    tick();
    n_checks++;
    if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL single_edge_n1: got %h expected %h", obs, NOP_BEAT); end
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL single_beat: got %h expected %h", obs, e); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL single_then_nop: got %h expected %h", obs, NOP_BEAT); end
    end
  endtask

  task automatic test_frame();
    beat_t e;
    frame_start = 1;
    push_frame();
    tick();
    frame_start = 0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_pending: got %b expected 1", busy); end
    n_checks++;
    if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL frame_lat_n: got %h expected %h", obs, NOP_BEAT); end
    tick();
    n_checks++;
    if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL frame_lat_n1: got %h expected %h", obs, NOP_BEAT); end
    for (int i = 0; i < H * V; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL frame_pixel %0d: got %h expected %h", i, obs, e); end
    end
    tick();
    n_checks++;
    if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL frame_after_nop: got %h expected %h", obs, NOP_BEAT); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_fifo_full();
    beat_t e;
    int accepted = 0;
    int attempts = 0;
    int cyc = 0;
    bit seen_done = 0;
    frame_start = 1;
    push_frame();
    tick();
    frame_start = 0;
    while (!seen_done && cyc < 200) begin
      if (attempts < 20) begin
        cmd_valid = 1;
        cmd_stage = 12'(accepted + 100);
        cmd_reg   = 12'(accepted * 2);
        cmd_data  = 12'(accepted * 7 + 1);
        attempts++;
      end else begin
        cmd_valid = 0;
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(mk(1'b1, cmd_stage, cmd_reg, cmd_data, 1'b0));
        accepted++;
      end
      tick();
      cyc++;
      if (!is_nop(obs)) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL full_unexpected_beat: got %h expected none", obs);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (obs !== e) begin n_fail++; $display("FAIL full_scan_beat: got %h expected %h", obs, e); end
        end
        if (obs.done) seen_done = 1;
      end
    end
    cmd_valid = 0;
    n_checks++;
    if (!seen_done) begin n_fail++; $display("FAIL full_timeout: got no frame_done expected one within 200 cycles"); end
    n_checks++;
    if (accepted !== 16) begin n_fail++; $display("FAIL full_accept_count: got %0d expected 16", accepted); end
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", cmd_ready); end
    for (int i = 0; i < 16; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL full_prog_missing %0d: got %h expected queued command", i, obs);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL full_prog %0d: got %h expected %h", i, obs, e); end
      end
    end
    tick();
    n_checks++;
    if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL full_after_nop: got %h expected %h", obs, NOP_BEAT); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_queue_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    beat_t e;
    int cyc = 0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid   = 1;
      cmd_stage   = 12'(i + 1);
      cmd_reg     = 12'(i + 10);
      cmd_data    = 12'(i * 100 + 5);
      frame_start = (i == 1);
      exp_q.push_back(mk(1'b1, cmd_stage, cmd_reg, cmd_data, 1'b0));
      tick();
    end
    cmd_valid = 0; frame_start = 0;
    push_frame();
    while (is_nop(obs) && cyc < 10) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 0) begin n_fail++; $display("FAIL b2b_first_latency: got %0d extra cycles expected 0", cyc); end
    for (int i = 0; i < 3 + H * V; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL b2b_beat %0d: got %h expected %h", i, obs, e); end
      tick();
    end
    n_checks++;
    if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL b2b_after_nop: got %h expected %h", obs, NOP_BEAT); end
  endtask

  task automatic test_reset_mid_scan();
    frame_start = 1;
    tick();
    frame_start = 0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1;
      cmd_stage = 12'(i + 200); cmd_reg = 12'(i); cmd_data = 12'(i + 1);
      tick();
    end
    cmd_valid = 0;
    repeat (6) tick();
    rst_n = 0;
    tick();
    n_checks++;
    if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL midrst_nop: got %h expected %h", obs, NOP_BEAT); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", cmd_ready); end
    tick();
    rst_n = 1;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (obs !== NOP_BEAT) begin n_fail++; $display("FAIL midrst_after %0d: got %h expected %h", i, obs, NOP_BEAT); end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after: got %b expected 0", busy); end
  endtask

  initial begin
    rst_n = 0; cmd_valid = 0; frame_start = 0;
    cmd_stage = '0; cmd_reg = '0; cmd_data = '0;
    obs = NOP_BEAT;
    test_reset();
    test_single_cmd();
    test_frame();
    test_fifo_full();
    repeat (3) tick();
    test_back_to_back();
    repeat (3) tick();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
